// File: rtl/vending_pkg.sv
// Shared definitions for the multi-coin vending machine.
// Holds the coin code constants and the controller state encoding so the
// top level and its sub-module agree on a single definition.
package vending_pkg;

    // Coin acceptor codes.
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_C1   = 2'b01;
    localparam logic [1:0] COIN_C2   = 2'b10;
    localparam logic [1:0] COIN_C3   = 2'b11;

    // Controller states. IDLE and COLLECT differ only in whether credit is held.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

endpackage

// File: rtl/coin_value_decode.sv
// Combinational coin code to credit value decoder.
// Ports:
//   i_coin  - 2-bit coin code from the acceptor (00 = no coin)
//   o_value - credit value of that coin, 0 when no coin is present
module coin_value_decode
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 8,
    parameter int VAL_C1   = 5,
    parameter int VAL_C2   = 10,
    parameter int VAL_C3   = 20
) (
    input  logic [1:0]          i_coin,
    output logic [CREDIT_W-1:0] o_value
);

    always_comb begin
        o_value = '0;
        case (i_coin)
            COIN_C1: o_value = CREDIT_W'(VAL_C1);
            COIN_C2: o_value = CREDIT_W'(VAL_C2);
            COIN_C3: o_value = CREDIT_W'(VAL_C3);
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/vending_machine_credit.sv
// Multi-coin, multi-product vending controller.
// Accumulates credit from coins, sells one of NUM_ITEMS products at a
// run-time price, and returns change or a full refund through a
// valid/ack handshake to the change hopper.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   coin          - coin code, one coin per cycle
//   sel_valid/sel - product selection strobe and index
//   cancel        - refund request
//   price_tbl     - packed per-item prices, item i at [i*CREDIT_W +: CREDIT_W]
//   change_ack    - hopper has taken change_amt
//   dispense      - one-hot one-cycle dispense pulse
//   change_valid  - change_amt valid, held until change_ack
//   change_amt    - change or refund value
//   credit        - current credit for display
//   coin_reject   - one-cycle pulse, coin returned
//   sel_nak       - one-cycle pulse, selection refused
//   busy          - high while dispensing or returning change
module vending_machine_credit
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 100,
    parameter int VAL_C1     = 5,
    parameter int VAL_C2     = 10,
    parameter int VAL_C3     = 20,
    localparam int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    coin,
    input  logic                          sel_valid,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          cancel,
    input  logic [NUM_ITEMS*CREDIT_W-1:0] price_tbl,
    input  logic                          change_ack,
    output logic [NUM_ITEMS-1:0]          dispense,
    output logic                          change_valid,
    output logic [CREDIT_W-1:0]           change_amt,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          coin_reject,
    output logic                          sel_nak,
    output logic                          busy
);

    state_t                r_state, w_state_nxt;
    logic [CREDIT_W-1:0]   r_credit, w_credit_nxt;
    logic [SEL_W-1:0]      r_idx, w_idx_nxt;
    logic [CREDIT_W-1:0]   r_price, w_price_nxt;
    logic [NUM_ITEMS-1:0]  r_dispense, w_dispense_nxt;
    logic                  r_coin_reject, w_coin_reject_nxt;
    logic                  r_sel_nak, w_sel_nak_nxt;

    logic [CREDIT_W-1:0]   w_coin_val;
    logic [CREDIT_W:0]     w_sum;
    logic                  w_coin_present;
    logic                  w_sel_in_range;
    logic [CREDIT_W-1:0]   w_sel_price;
    logic [CREDIT_W-1:0]   w_remainder;

    coin_value_decode #(
        .CREDIT_W (CREDIT_W),
        .VAL_C1   (VAL_C1),
        .VAL_C2   (VAL_C2),
        .VAL_C3   (VAL_C3)
    ) u_coin_dec (
        .i_coin  (coin),
        .o_value (w_coin_val)
    );

    assign w_coin_present = (coin != COIN_NONE);
    // One extra bit so an over-ceiling sum can never wrap into a legal value.
    assign w_sum          = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_remainder    = r_credit - r_price;

    // Price lookup; an index beyond NUM_ITEMS leaves w_sel_in_range low.
    always_comb begin
        w_sel_in_range = 1'b0;
        w_sel_price    = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_in_range = 1'b1;
                w_sel_price    = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_dispense    <= '0;
            r_coin_reject <= 1'b0;
            r_sel_nak     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_dispense    <= w_dispense_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_sel_nak     <= w_sel_nak_nxt;
        end
    end

    // Sale bookkeeping is only meaningful once DISPENSE is entered.
    always_ff @(posedge clk) begin
        r_idx   <= w_idx_nxt;
        r_price <= w_price_nxt;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_idx_nxt         = r_idx;
        w_price_nxt       = r_price;
        w_dispense_nxt    = '0;
        w_coin_reject_nxt = 1'b0;
        w_sel_nak_nxt     = 1'b0;

        case (r_state)
            IDLE, COLLECT: begin
                if (cancel) begin
                    // Cancel outranks everything; a selection here is dropped silently.
                    if (r_credit != '0) begin
                        w_state_nxt = CHANGE;
                    end
                    w_coin_reject_nxt = w_coin_present;
                end else if (sel_valid && w_sel_in_range && (r_credit >= w_sel_price)) begin
                    w_idx_nxt         = sel;
                    w_price_nxt       = w_sel_price;
                    w_state_nxt       = DISPENSE;
                    w_coin_reject_nxt = w_coin_present;
                end else begin
                    // A refused selection does not block a coin in the same cycle.
                    w_sel_nak_nxt = sel_valid;
                    if (w_coin_present) begin
                        if (w_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                            w_credit_nxt = w_sum[CREDIT_W-1:0];
                            w_state_nxt  = COLLECT;
                        end else begin
                            w_coin_reject_nxt = 1'b1;
                        end
                    end
                end
            end

            DISPENSE: begin
                w_dispense_nxt    = NUM_ITEMS'(1) << r_idx;
                w_credit_nxt      = w_remainder;
                w_state_nxt       = (w_remainder != '0) ? CHANGE : IDLE;
                w_coin_reject_nxt = w_coin_present;
            end

            CHANGE: begin
                w_coin_reject_nxt = w_coin_present;
                if (change_ack) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = IDLE;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    assign dispense     = r_dispense;
    assign coin_reject  = r_coin_reject;
    assign sel_nak      = r_sel_nak;
    assign credit       = r_credit;
    assign change_valid = (r_state == CHANGE);
    assign change_amt   = (r_state == CHANGE) ? r_credit : '0;
    assign busy         = (r_state == DISPENSE) || (r_state == CHANGE);

endmodule

// File: tb/tb_vending_machine_credit.sv
module tb_vending_machine_credit;

    localparam int NUM_ITEMS = 4;
    localparam int CREDIT_W  = 8;
    localparam int SEL_W     = 2;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [1:0]                    coin;
    logic                          sel_valid;
    logic [SEL_W-1:0]              sel;
    logic                          cancel;
    logic [NUM_ITEMS*CREDIT_W-1:0] price_tbl;
    logic                          change_ack;
    logic [NUM_ITEMS-1:0]          dispense;
    logic                          change_valid;
    logic [CREDIT_W-1:0]           change_amt;
    logic [CREDIT_W-1:0]           credit;
    logic                          coin_reject;
    logic                          sel_nak;
    logic                          busy;

    int tests = 0;
    int fails = 0;

    vending_machine_credit dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .price_tbl    (price_tbl),
        .change_ack   (change_ack),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .sel_nak      (sel_nak),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin = 2'b00; sel_valid = 1'b0; sel = '0; cancel = 1'b0; change_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests++; if (credit !== 8'd0) begin fails++; $display("FAIL rst_credit: got %0d want 0", credit); end
        tests++; if (dispense !== 4'b0000) begin fails++; $display("FAIL rst_dispense: got %b want 0000", dispense); end
        tests++; if ({change_valid, coin_reject, sel_nak, busy} !== 4'b0000) begin fails++; $display("FAIL rst_flags: got %b want 0000", {change_valid, coin_reject, sel_nak, busy}); end
        tests++; if (change_amt !== 8'd0) begin fails++; $display("FAIL rst_amt: got %0d want 0", change_amt); end
    endtask

    task automatic test_exact_sale();
        coin = 2'b01; tick();
        tests++; if (credit !== 8'd5) begin fails++; $display("FAIL t1_credit5: got %0d want 5", credit); end
        coin = 2'b10; tick();
        tests++; if (credit !== 8'd15) begin fails++; $display("FAIL t1_credit15: got %0d want 15", credit); end
        coin = 2'b00; sel_valid = 1'b1; sel = 2'd0; tick();
        sel_valid = 1'b0;
        tests++; if (busy !== 1'b1 || dispense !== 4'b0000) begin fails++; $display("FAIL t1_dispense_state: got busy=%b disp=%b want 1 0000", busy, dispense); end
        tick();
        tests++; if (dispense !== 4'b0001) begin fails++; $display("FAIL t1_dispense: got %b want 0001", dispense); end
        tests++; if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL t1_after: got credit=%0d cv=%b busy=%b want 0 0 0", credit, change_valid, busy); end
        tick();
        tests++; if (dispense !== 4'b0000 || change_valid !== 1'b0) begin fails++; $display("FAIL t1_pulse: got disp=%b cv=%b want 0000 0", dispense, change_valid); end
    endtask

    task automatic test_sale_with_change();
        coin = 2'b11; tick(); tick();
        coin = 2'b00;
        tests++; if (credit !== 8'd40) begin fails++; $display("FAIL t2_credit40: got %0d want 40", credit); end
        sel_valid = 1'b1; sel = 2'd1; tick();
        sel_valid = 1'b0; tick();
        tests++; if (dispense !== 4'b0010) begin fails++; $display("FAIL t2_dispense: got %b want 0010", dispense); end
        tests++; if (change_valid !== 1'b1 || change_amt !== 8'd15) begin fails++; $display("FAIL t2_change: got cv=%b amt=%0d want 1 15", change_valid, change_amt); end
        for (int i = 0; i < 3; i++) begin
            coin = (i == 1) ? 2'b01 : 2'b00;
            tick();
            tests++; if (change_valid !== 1'b1 || change_amt !== 8'd15 || dispense !== 4'b0000) begin fails++; $display("FAIL t2_hold%0d: got cv=%b amt=%0d disp=%b want 1 15 0000", i, change_valid, change_amt, dispense); end
            tests++; if (coin_reject !== (i == 1)) begin fails++; $display("FAIL t2_busy_reject%0d: got %b want %b", i, coin_reject, (i == 1)); end
        end
        coin = 2'b00; change_ack = 1'b1; tick();
        change_ack = 1'b0;
        tests++; if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL t2_ack: got credit=%0d cv=%b busy=%b want 0 0 0", credit, change_valid, busy); end
    endtask

    task automatic test_nak_and_cancel();
        coin = 2'b10; tick();
        coin = 2'b00; sel_valid = 1'b1; sel = 2'd2; tick();
        sel_valid = 1'b0;
        tests++; if (sel_nak !== 1'b1 || credit !== 8'd10 || busy !== 1'b0) begin fails++; $display("FAIL t3_nak: got nak=%b credit=%0d busy=%b want 1 10 0", sel_nak, credit, busy); end
        tick();
        tests++; if (sel_nak !== 1'b0 || dispense !== 4'b0000) begin fails++; $display("FAIL t3_nak_pulse: got nak=%b disp=%b want 0 0000", sel_nak, dispense); end
        change_ack = 1'b1; tick();
        change_ack = 1'b0;
        tests++; if (change_valid !== 1'b0 || credit !== 8'd10) begin fails++; $display("FAIL t3_stray_ack: got cv=%b credit=%0d want 0 10", change_valid, credit); end
        cancel = 1'b1; tick();
        cancel = 1'b0;
        tests++; if (change_valid !== 1'b1 || change_amt !== 8'd10) begin fails++; $display("FAIL t3_refund: got cv=%b amt=%0d want 1 10", change_valid, change_amt); end
        change_ack = 1'b1; tick();
        change_ack = 1'b0;
        tests++; if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin fails++; $display("FAIL t3_ack: got cv=%b credit=%0d busy=%b want 0 0 0", change_valid, credit, busy); end
    endtask

    task automatic test_ceiling();
        coin = 2'b11;
        for (int i = 0; i < 5; i++) tick();
        tests++; if (credit !== 8'd100 || coin_reject !== 1'b0) begin fails++; $display("FAIL t4_full: got credit=%0d rej=%b want 100 0", credit, coin_reject); end
        tick();
        tests++; if (coin_reject !== 1'b1 || credit !== 8'd100) begin fails++; $display("FAIL t4_reject: got rej=%b credit=%0d want 1 100", coin_reject, credit); end
        coin = 2'b01; tick();
        tests++; if (coin_reject !== 1'b1 || credit !== 8'd100) begin fails++; $display("FAIL t4_reject_c1: got rej=%b credit=%0d want 1 100", coin_reject, credit); end
        coin = 2'b00; tick();
        tests++; if (coin_reject !== 1'b0) begin fails++; $display("FAIL t4_reject_pulse: got %b want 0", coin_reject); end
        sel_valid = 1'b1; sel = 2'd3; tick();
        sel_valid = 1'b0; tick();
        tests++; if (dispense !== 4'b1000 || credit !== 8'd0 || change_valid !== 1'b0) begin fails++; $display("FAIL t4_sale: got disp=%b credit=%0d cv=%b want 1000 0 0", dispense, credit, change_valid); end
        tick();
    endtask

    task automatic test_priority();
        coin = 2'b11; tick();
        tests++; if (credit !== 8'd20) begin fails++; $display("FAIL t5_credit20: got %0d want 20", credit); end
        cancel = 1'b1; sel_valid = 1'b1; sel = 2'd0; coin = 2'b01; tick();
        idle_inputs();
        tests++; if (change_valid !== 1'b1 || change_amt !== 8'd20 || coin_reject !== 1'b1) begin fails++; $display("FAIL t5_cancel: got cv=%b amt=%0d rej=%b want 1 20 1", change_valid, change_amt, coin_reject); end
        tests++; if (sel_nak !== 1'b0 || dispense !== 4'b0000) begin fails++; $display("FAIL t5_no_sale: got nak=%b disp=%b want 0 0000", sel_nak, dispense); end
        tick();
        tests++; if (dispense !== 4'b0000 || change_valid !== 1'b1) begin fails++; $display("FAIL t5_hold: got disp=%b cv=%b want 0000 1", dispense, change_valid); end
        change_ack = 1'b1; tick();
        change_ack = 1'b0;
        tests++; if (change_valid !== 1'b0 || credit !== 8'd0) begin fails++; $display("FAIL t5_ack: got cv=%b credit=%0d want 0 0", change_valid, credit); end
    endtask

    task automatic test_reset_in_change();
        coin = 2'b01; tick();
        coin = 2'b10; tick();
        coin = 2'b00; cancel = 1'b1; tick();
        cancel = 1'b0;
        tests++; if (change_valid !== 1'b1 || change_amt !== 8'd15) begin fails++; $display("FAIL t6_change: got cv=%b amt=%0d want 1 15", change_valid, change_amt); end
        reset = 1'b1; tick();
        reset = 1'b0;
        tests++; if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin fails++; $display("FAIL t6_reset: got cv=%b credit=%0d busy=%b want 0 0 0", change_valid, credit, busy); end
        coin = 2'b01; tick();
        coin = 2'b00;
        tests++; if (credit !== 8'd5) begin fails++; $display("FAIL t6_after: got %0d want 5", credit); end
    endtask

    initial begin
        price_tbl = {8'd100, 8'd40, 8'd25, 8'd15};
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_exact_sale();
        test_sale_with_change();
        test_nak_and_cancel();
        test_ceiling();
        test_priority();
        test_reset_in_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
